// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states, grant encoding and
// default timing.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int unsigned DEF_ADDR_W   = 20;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_RD_WAIT  = 0;
    localparam int unsigned DEF_WR_PULSE = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between fetch (I) and data (D) requesters.
// A contested request goes to the port that did not win the previous grant.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic clk_10M,
    input  logic reset_of_clk10M,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant
);

    logic last_grant_q;

    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant = ~last_grant_q;
        end else begin
            grant = d_req ? GNT_D : GNT_I;
        end
    end

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            last_grant_q <= GNT_I;
        end else if (grant_en && grant_valid) begin
            last_grant_q <= grant;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM bank between the fetch and data ports. Every SRAM pin and
// ack is a flop, updated on the state transition that enters the state it belongs to.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RD_WAIT  = DEF_RD_WAIT,
    parameter int unsigned WR_PULSE = DEF_WR_PULSE
) (
    input  logic                clk_10M,
    input  logic                reset_of_clk10M,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_dq_i,
    output logic [DATA_W-1:0]   sram_dq_o,
    output logic                sram_dq_oe,
    output logic [DATA_W/8-1:0] sram_be_n,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                busy
);

    if (RD_WAIT > 7) begin : g_bad_rd_wait
        $error("RD_WAIT must be within 0..7");
    end
    if (WR_PULSE < 1 || WR_PULSE > 7) begin : g_bad_wr_pulse
        $error("WR_PULSE must be within 1..7");
    end

    // Counters are loaded on state entry and the state exits when they reach zero.
    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_PULSE - 1);

    state_e     state_q;
    logic [2:0] cnt_q;
    logic       gnt_q;
    logic       grant_valid;
    logic       grant;

    rr_arb2 u_rr_arb2 (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .i_req           (i_req),
        .d_req           (d_req),
        .grant_en        (state_q == StIdle),
        .grant_valid     (grant_valid),
        .grant           (grant)
    );

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gnt_q      <= GNT_I;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_be_n  <= '1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        gnt_q     <= grant;
                        sram_ce_n <= 1'b0;
                        if (grant == GNT_D && d_we) begin
                            sram_addr  <= d_addr;
                            sram_dq_o  <= d_wdata;
                            sram_be_n  <= ~d_be;
                            sram_dq_oe <= 1'b1;
                            state_q    <= StWrSetup;
                        end else begin
                            sram_addr <= (grant == GNT_D) ? d_addr : i_addr;
                            sram_be_n <= '0;
                            sram_oe_n <= 1'b0;
                            cnt_q     <= RD_CNT;
                            state_q   <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (cnt_q == 3'd0) begin
                        if (gnt_q == GNT_D) begin
                            d_rdata <= sram_dq_i;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= sram_dq_i;
                            i_ack   <= 1'b1;
                        end
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StWrSetup: begin
                    sram_we_n <= 1'b0;
                    cnt_q     <= WR_CNT;
                    state_q   <= StWrPulse;
                end
                StWrPulse: begin
                    if (cnt_q == 3'd0) begin
                        sram_we_n <= 1'b1;
                        state_q   <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StWrHold: begin
                    // Writes only ever come from the data port.
                    d_ack      <= 1'b1;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_be_n  <= '1;
                    state_q    <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter with a behavioural SRAM pad, a
// transaction-level arbitration/timing model, and a second instance with slow timing.
module tb_sram_port_arbiter;

    localparam int unsigned RDW   = 0;
    localparam int unsigned WRP   = 1;
    localparam int          N_TXN = 150;

    logic clk_10M = 1'b0;
    logic reset_of_clk10M = 1'b0;
    always #5 clk_10M = ~clk_10M;

    logic        i_req = 1'b0, i_ack;
    logic [19:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_ack;
    logic [3:0]  d_be = '0;
    logic [19:0] d_addr = '0;
    logic [31:0] d_wdata = '0, d_rdata;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;
    logic [3:0]  sram_be_n;

    sram_port_arbiter dut (
        .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy)
    );

    // Slow-timing instance, exercised by a short directed sequence.
    logic        t_i_req = 1'b0, t_i_ack, t_d_req = 1'b0, t_d_ack;
    logic [31:0] t_i_rdata, t_d_rdata, t_dq_i, t_dq_o;
    logic [19:0] t_addr;
    logic        t_dq_oe, t_ce_n, t_oe_n, t_we_n, t_busy;
    logic [3:0]  t_be_n;

    sram_port_arbiter #(.RD_WAIT(2), .WR_PULSE(3)) dut_t (
        .clk_10M(clk_10M), .reset_of_clk10M(reset_of_clk10M),
        .i_req(t_i_req), .i_addr(20'h00005), .i_ack(t_i_ack), .i_rdata(t_i_rdata),
        .d_req(t_d_req), .d_we(1'b1), .d_be(4'hF), .d_addr(20'h00007),
        .d_wdata(32'h0BADF00D), .d_ack(t_d_ack), .d_rdata(t_d_rdata),
        .sram_addr(t_addr), .sram_dq_i(t_dq_i), .sram_dq_o(t_dq_o), .sram_dq_oe(t_dq_oe),
        .sram_be_n(t_be_n), .sram_ce_n(t_ce_n), .sram_oe_n(t_oe_n), .sram_we_n(t_we_n),
        .busy(t_busy)
    );
    assign t_dq_i = (!t_ce_n && !t_oe_n) ? 32'hCAFEF00D : 32'h0;

    int checks = 0;
    int passes = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Pad model: word array indexed by the low 6 address bits. Fetch addresses use words
    // 0..31 (never written), data addresses use 32..63.
    logic [31:0] sram_mem [64];
    logic [31:0] ref_mem  [64];
    logic [31:0] noise = 32'h0;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : noise;

    always @(negedge clk_10M) begin
        noise = $urandom;
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram_mem[sram_addr[5:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
    end

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];

    task automatic fetch_txn(input logic [19:0] a);
        txn_t t;
        bit   got = 1'b0;
        t.we = 1'b0; t.be = 4'hF; t.addr = a; t.wdata = '0; t.rdata = ref_mem[a[5:0]];
        iq.push_back(t);
        i_addr = a;
        i_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_10M);
            if (i_ack) begin got = 1'b1; break; end
        end
        check(got, "i_ack_arrives", 64'(got), 64'd1);
        @(posedge clk_10M); #1;
        i_req  = 1'b0;
        i_addr = 20'($urandom);
    endtask

    task automatic data_txn(input logic we, input logic [19:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        txn_t t;
        bit   got = 1'b0;
        t.we = we; t.be = be; t.addr = a; t.wdata = wd; t.rdata = ref_mem[a[5:0]];
        dq.push_back(t);
        d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_10M);
            if (d_ack) begin got = 1'b1; break; end
        end
        check(got, "d_ack_arrives", 64'(got), 64'd1);
        if (got && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a[5:0]][8*b +: 8] = wd[8*b +: 8];
        @(posedge clk_10M); #1;
        d_req = 1'b0; d_we = 1'($urandom); d_addr = 20'($urandom);
        d_wdata = $urandom; d_be = 4'($urandom);
    endtask

    // Monitor: per-cycle pin history, checked back from every ack against the expected
    // grant cycle, arbitration decision and pin sequence of that transaction.
    typedef struct packed {
        logic        ireq, dreq, busy, ce_n, oe_n, we_n, oe;
        logic [3:0]  be_n;
        logic [19:0] addr;
        logic [31:0] dq;
    } snap_t;

    snap_t hist [64];
    int    cyc = 0;
    int    last_ack = 0;
    logic  last_g = 1'b0;
    txn_t  m_e;
    snap_t m_s;
    logic  m_p, m_exp;
    int    m_g;
    bit    m_ok;

    function automatic snap_t h(input int c);
        return hist[c[5:0]];
    endfunction

    function automatic bit pins_ok(input snap_t s, input logic ce_n, input logic oe_n,
                                   input logic we_n, input logic oe, input logic [3:0] be_n,
                                   input logic [19:0] a, input bit cmp_dq, input logic [31:0] dq);
        return s.busy && s.ce_n == ce_n && s.oe_n == oe_n && s.we_n == we_n && s.oe == oe &&
               s.be_n == be_n && s.addr == a && (!cmp_dq || s.dq == dq);
    endfunction

    always @(negedge clk_10M) begin
        cyc++;
        hist[cyc[5:0]] = '{i_req, d_req, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe,
                           sram_be_n, sram_addr, sram_dq_o};
        if (reset_of_clk10M) begin
            last_ack = cyc;
            last_g   = 1'b0;
        end else if (i_ack || d_ack) begin
            check(!(i_ack && d_ack), "ack_exclusive", 64'({i_ack, d_ack}), 64'd1);
            m_p = d_ack;
            if (m_p ? dq.size() == 0 : iq.size() == 0) begin
                check(1'b0, "unexpected_ack", 64'(m_p), 64'd0);
            end else begin
                m_e = m_p ? dq.pop_front() : iq.pop_front();
                m_g = cyc - (m_e.we ? 3 + WRP : 2 + RDW);
                m_s = h(m_g);
                m_exp = (m_s.ireq && m_s.dreq) ? ~last_g : m_s.dreq;
                check((m_s.ireq || m_s.dreq) && m_p == m_exp, "grant_port", 64'(m_p),
                      64'(m_exp));
                // No request may have been left waiting while the arbiter was idle.
                m_ok = (m_g > last_ack);
                for (int c = last_ack + 1; c < m_g; c++)
                    if (c > m_g - 60 && (h(c).ireq || h(c).dreq)) m_ok = 1'b0;
                check(m_ok, "grant_cycle", 64'(m_g), 64'(last_ack + 1));
                last_g   = m_p;
                last_ack = cyc;
                if (!m_e.we) begin
                    if (m_p) check(d_rdata == m_e.rdata, "d_rdata", 64'(d_rdata), 64'(m_e.rdata));
                    else     check(i_rdata == m_e.rdata, "i_rdata", 64'(i_rdata), 64'(m_e.rdata));
                end
                m_ok = !m_s.busy && m_s.ce_n && m_s.oe_n && m_s.we_n && !m_s.oe;
                if (m_e.we) begin
                    m_ok &= pins_ok(h(m_g + 1), 0, 1, 1, 1, ~m_e.be, m_e.addr, 1, m_e.wdata);
                    for (int k = 1; k <= WRP; k++)
                        m_ok &= pins_ok(h(m_g + 1 + k), 0, 1, 0, 1, ~m_e.be, m_e.addr, 1,
                                        m_e.wdata);
                    m_ok &= pins_ok(h(m_g + 2 + WRP), 0, 1, 1, 1, ~m_e.be, m_e.addr, 1,
                                    m_e.wdata);
                end else begin
                    for (int k = 1; k <= 1 + RDW; k++)
                        m_ok &= pins_ok(h(m_g + k), 0, 0, 1, 0, 4'h0, m_e.addr, 0, '0);
                end
                m_s = h(cyc);
                m_ok &= m_s.busy && m_s.ce_n && m_s.oe_n && m_s.we_n && !m_s.oe;
                check(m_ok, m_p ? "d_pin_sequence" : "i_pin_sequence", 64'(m_ok), 64'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

    logic [19:0] a_i, a_d;
    int          gap_i, gap_d, n_cyc, n_low;
    bit          got, seen;

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[16] = 32'h12345678;
        ref_mem[16]  = 32'h12345678;

        #2 reset_of_clk10M = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_10M); #1;
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            i_addr = 20'($urandom); d_addr = 20'($urandom);
            @(negedge clk_10M);
            check(sram_ce_n && sram_oe_n && sram_we_n && !sram_dq_oe && sram_be_n == 4'hF &&
                  sram_addr == '0 && !i_ack && !d_ack && i_rdata == '0 && d_rdata == '0 &&
                  !busy, "reset_state", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe,
                  i_ack, d_ack}), 64'b111000);
        end
        @(posedge clk_10M); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk_10M);
        reset_of_clk10M = 1'b0;
        @(posedge clk_10M); #1;

        // Slow-timing instance: read ack in cycle 5 with oe_n low 3 cycles, write ack in
        // cycle 7 with we_n low 3 cycles.
        t_i_req = 1'b1; n_cyc = 0; n_low = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_10M); n_cyc++;
            if (!t_oe_n) n_low++;
            if (t_i_ack) begin got = 1'b1; break; end
        end
        check(got && n_cyc == 5, "slow_read_ack_cycle", 64'(n_cyc), 64'd5);
        check(n_low == 3, "slow_read_oe_low", 64'(n_low), 64'd3);
        check(t_i_rdata == 32'hCAFEF00D, "slow_read_data", 64'(t_i_rdata), 64'hCAFEF00D);
        @(posedge clk_10M); #1;
        t_i_req = 1'b0; t_d_req = 1'b1; n_cyc = 0; n_low = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_10M); n_cyc++;
            if (!t_we_n) n_low++;
            if (t_d_ack) begin got = 1'b1; break; end
        end
        check(got && n_cyc == 7, "slow_write_ack_cycle", 64'(n_cyc), 64'd7);
        check(n_low == 3, "slow_write_we_low", 64'(n_low), 64'd3);
        @(posedge clk_10M); #1;
        t_d_req = 1'b0;

        fetch_txn(20'h00010);
        data_txn(1'b1, 20'h00ABC, 32'hDEADBEEF, 4'b0011);
        data_txn(1'b0, 20'h00ABC, 32'h0, 4'h0);
        // Back-to-back fetches: req stays high across each ack, address changes.
        for (int k = 0; k < 4; k++) begin
            a_i = 20'($urandom); a_i[5] = 1'b0;
            fetch_txn(a_i);
        end

        fork
            for (int n = 0; n < N_TXN; n++) begin
                gap_i = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                if (gap_i > 0) begin repeat (gap_i) @(posedge clk_10M); #1; end
                a_i = 20'($urandom); a_i[5] = 1'b0;
                fetch_txn(a_i);
            end
            for (int n = 0; n < N_TXN; n++) begin
                gap_d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                if (gap_d > 0) begin repeat (gap_d) @(posedge clk_10M); #1; end
                a_d = 20'($urandom); a_d[5:3] = 3'b100;
                data_txn(1'($urandom), a_d, $urandom, 4'($urandom));
            end
        join
        check(iq.size() == 0 && dq.size() == 0, "scoreboard_drained",
              64'(iq.size() + dq.size()), 64'd0);

        // Reset in the middle of a write pulse: pins drop asynchronously, no ack follows.
        @(posedge clk_10M); #1;
        d_we = 1'b1; d_addr = 20'h0003F; d_wdata = 32'hA5A5A5A5; d_be = 4'hF; d_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_10M);
            if (!sram_we_n) begin got = 1'b1; break; end
        end
        check(got, "reach_write_pulse", 64'(got), 64'd1);
        #2 reset_of_clk10M = 1'b1;
        #1;
        check(sram_we_n && !sram_dq_oe && sram_ce_n && !busy, "async_reset_pins",
              64'({sram_we_n, sram_dq_oe, sram_ce_n, busy}), 64'b1010);
        d_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk_10M);
            seen |= (i_ack || d_ack);
        end
        check(!seen, "no_ack_after_reset", 64'(seen), 64'd0);
        reset_of_clk10M = 1'b0;
        @(posedge clk_10M); #1;
        // First contested grant after reset must go to the data port.
        fork
            fetch_txn(20'h00010);
            data_txn(1'b0, 20'h00028, 32'h0, 4'h0);
        join
        check(iq.size() == 0 && dq.size() == 0, "scoreboard_drained_after_reset",
              64'(iq.size() + dq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
